// File: rtl/bird_column_ctrl.sv
// Bird controller for one LED-matrix column: gravity/flap on a divided game tick,
// ground and pipe collision detection, and a blinking bird while the game is over.
module bird_column_ctrl #(
  parameter int unsigned ROWS      = 8,
  parameter int unsigned TICK_DIV  = 1792,
  parameter int unsigned FLAP_ROWS = 2,
  parameter int unsigned START_ROW = 3,
  parameter int unsigned SCORE_W   = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flap,
  input  logic                     restart,
  input  logic                     collide,
  output logic [ROWS-1:0]          lightCol,
  output logic [$clog2(ROWS)-1:0]  birdRow,
  output logic                     tick,
  output logic                     gameOver,
  output logic [SCORE_W-1:0]       score
);

  localparam int unsigned RowW = $clog2(ROWS);
  localparam int unsigned CntW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  localparam logic [RowW-1:0]    StartRow = RowW'(START_ROW);
  localparam logic [RowW-1:0]    TopRow   = RowW'(ROWS - 1);
  localparam logic [CntW-1:0]    CntMax   = CntW'(TICK_DIV - 1);
  localparam logic [SCORE_W-1:0] ScoreMax = '1;
  localparam logic [ROWS-1:0]    RowOne   = ROWS'(1);

  typedef enum logic [1:0] {
    StIdle,
    StFly,
    StDead
  } state_e;

  state_e              state_q, state_d;
  logic [RowW-1:0]     row_q, row_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                pending_q, pending_d;
  logic                flap_q;
  logic                blink_q, blink_d;
  logic [SCORE_W-1:0]  score_q, score_d;

  logic                tick_now;
  logic                press;
  logic                flap_now;
  logic [RowW-1:0]     row_raised;
  logic [SCORE_W-1:0]  score_inc;
  int unsigned         row_sum;

  assign tick_now = (cnt_q == CntMax);
  assign press    = flap & ~flap_q;
  assign flap_now = pending_q | press;

  // Raise is computed in 32 bits so the ceiling clamp cannot wrap.
  always_comb begin
    row_sum    = 32'(row_q) + FLAP_ROWS;
    row_raised = (row_sum >= ROWS - 1) ? TopRow : RowW'(row_sum);
  end

  assign score_inc = (score_q == ScoreMax) ? score_q : score_q + SCORE_W'(1);

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    pending_d = pending_q;
    blink_d   = blink_q;
    score_d   = score_q;
    cnt_d     = tick_now ? '0 : cnt_q + CntW'(1);

    if (restart) begin
      state_d   = StIdle;
      row_d     = StartRow;
      pending_d = 1'b0;
      blink_d   = 1'b1;
      score_d   = '0;
      cnt_d     = '0;
    end else begin
      case (state_q)
        StIdle: begin
          row_d = StartRow;
          if (press) begin
            state_d   = StFly;
            pending_d = 1'b1;
          end
        end

        StFly: begin
          if (collide) begin
            // Collision wins over a coincident tick: no move, no score.
            state_d   = StDead;
            pending_d = 1'b0;
            blink_d   = 1'b1;
          end else begin
            if (press) begin
              pending_d = 1'b1;
            end
            if (tick_now) begin
              pending_d = 1'b0;
              if (flap_now) begin
                row_d   = row_raised;
                score_d = score_inc;
              end else if (row_q == '0) begin
                state_d = StDead;
                blink_d = 1'b1;
              end else begin
                row_d   = row_q - RowW'(1);
                score_d = score_inc;
              end
            end
          end
        end

        StDead: begin
          pending_d = 1'b0;
          if (tick_now) begin
            blink_d = ~blink_q;
          end
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      row_q     <= StartRow;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      flap_q    <= 1'b0;
      blink_q   <= 1'b1;
      score_q   <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      flap_q    <= flap;
      blink_q   <= blink_d;
      score_q   <= score_d;
    end
  end

  always_comb begin
    lightCol = '0;
    if ((state_q != StDead) || blink_q) begin
      lightCol = RowOne << row_q;
    end
  end

  assign birdRow  = row_q;
  assign tick     = tick_now;
  assign gameOver = (state_q == StDead);
  assign score    = score_q;

endmodule
